// File: rtl/debug_dump_ctrl.sv
// Debug dump controller: optionally single-steps a halted core, then sweeps
// its debug address space and streams each captured word over valid/ready.
module debug_dump_ctrl #(
    parameter int unsigned ADDR_FIRST = 0,
    parameter int unsigned ADDR_LAST  = 63,
    parameter int unsigned STEP_CYC   = 4,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt_req,
    input  logic        start,
    input  logic        mode,
    output logic        busy,
    output logic        done,
    output logic        debug_en,
    output logic        debug_step,
    output logic [6:0]  debug_addr,
    input  logic [31:0] debug_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [6:0]  out_addr,
    output logic [31:0] out_data
);

    localparam int unsigned ADDR_W  = 7;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CNT_MAX = (STEP_CYC > SETTLE_CYC) ? STEP_CYC : SETTLE_CYC;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [ADDR_W-1:0] FIRST      = ADDR_W'(ADDR_FIRST);
    localparam logic [ADDR_W-1:0] LAST       = ADDR_W'(ADDR_LAST);
    localparam logic [CNT_W-1:0]  STEP_END   = CNT_W'(STEP_CYC - 1);
    localparam logic [CNT_W-1:0]  SETTLE_END = CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        STEP_HI,
        STEP_LO,
        SETTLE,
        SEND,
        DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [ADDR_W-1:0]   oaddr_nxt;
    logic [DATA_W-1:0]   odata_nxt;

    // State, counter and all outputs; flag outputs decode the next state so
    // they line up with the state they describe and stay glitch-free.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            debug_addr <= '0;
            out_addr   <= '0;
            out_data   <= '0;
            debug_en   <= 1'b0;
            debug_step <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            debug_addr <= addr_nxt;
            out_addr   <= oaddr_nxt;
            out_data   <= odata_nxt;
            debug_en   <= halt_req;
            debug_step <= (state_nxt == STEP_HI);
            busy       <= (state_nxt != IDLE);
            done       <= (state_nxt == DONE);
            out_valid  <= (state_nxt == SEND);
        end
    end

    // Next-state, cycle counter, sweep address and capture logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        addr_nxt  = debug_addr;
        oaddr_nxt = out_addr;
        odata_nxt = out_data;
        unique case (state)
            IDLE: begin
                if (start) begin
                    cnt_nxt = '0;
                    if (mode && debug_en) begin
                        state_nxt = STEP_HI;
                    end else begin
                        addr_nxt  = FIRST;
                        state_nxt = SETTLE;
                    end
                end
            end
            STEP_HI: begin
                if (cnt == STEP_END) begin
                    cnt_nxt   = '0;
                    state_nxt = STEP_LO;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            STEP_LO: begin
                if (cnt == STEP_END) begin
                    cnt_nxt   = '0;
                    addr_nxt  = FIRST;
                    state_nxt = SETTLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            SETTLE: begin
                if (cnt == SETTLE_END) begin
                    cnt_nxt   = '0;
                    oaddr_nxt = debug_addr;
                    odata_nxt = debug_data;
                    state_nxt = SEND;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (debug_addr == LAST) begin
                        state_nxt = DONE;
                    end else begin
                        addr_nxt  = debug_addr + ADDR_W'(1);
                        state_nxt = SETTLE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_debug_dump_ctrl.sv
// Self-checking bench for debug_dump_ctrl: vector table of whole operations,
// randomized operations, reset corner cases and a single-address sweep.
module tb_debug_dump_ctrl;

    localparam int STEP_CYC   = 4;
    localparam int SETTLE_CYC = 2;
    localparam int N_WORDS    = 64;
    localparam int BUDGET     = 3000;
    localparam int N_VEC      = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, halt_req, start, mode, out_ready;
    logic        busy, done, debug_en, debug_step, out_valid;
    logic [6:0]  debug_addr, out_addr;
    logic [31:0] debug_data, out_data;
    logic [31:0] seed;

    logic        start1;
    logic        busy1, done1, debug_en1, debug_step1, out_valid1;
    logic [6:0]  debug_addr1, out_addr1;
    logic [31:0] debug_data1, out_data1;

    // Core debug port model: data is a seeded hash of the address.
    function automatic logic [31:0] data_fn(input logic [6:0] a, input logic [31:0] s);
        return (32'(a) * 32'h9E37_79B9) ^ s;
    endfunction

    assign debug_data  = data_fn(debug_addr, seed);
    assign debug_data1 = {25'h0, debug_addr1};

    debug_dump_ctrl u_dut (
        .clk(clk), .rst(rst), .halt_req(halt_req), .start(start), .mode(mode),
        .busy(busy), .done(done), .debug_en(debug_en), .debug_step(debug_step),
        .debug_addr(debug_addr), .debug_data(debug_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data)
    );

    debug_dump_ctrl #(.ADDR_FIRST(32), .ADDR_LAST(32)) u_one (
        .clk(clk), .rst(rst), .halt_req(halt_req), .start(start1), .mode(1'b0),
        .busy(busy1), .done(done1), .debug_en(debug_en1), .debug_step(debug_step1),
        .debug_addr(debug_addr1), .debug_data(debug_data1), .out_valid(out_valid1),
        .out_ready(1'b1), .out_addr(out_addr1), .out_data(out_data1)
    );

    typedef struct {
        bit mode;
        bit halt;
        int kind;       // 0 ready always, 1 stall 10 cycles at addr 5, 2 random
        bit restart;
        bit halt_drop;
        int exp_step;
        int exp_lat;
        int exp_valid;  // -1 = not predicted
        int exp_done;   // -1 = not predicted
    } vec_t;

    vec_t vecs[N_VEC];

    int checks = 0;
    int errors = 0;

    int ncyc = 0;
    int op_base = 0;
    int m_words, m_first_valid, m_step_cnt, m_step_rises, m_step_first;
    int m_done_cnt, m_done_rel, m_busy_cnt, m_valid_cnt;
    logic [6:0]  m_exp_addr;
    bit          prev_ok = 1'b0;
    logic        prev_rst, prev_halt, prev_valid, prev_ready;
    logic        prev_step = 1'b0;
    logic [6:0]  prev_oaddr;
    logic [31:0] prev_odata;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Per-cycle observer run at the falling edge.
    task automatic monitor_sample();
        int rel;
        ncyc++;
        rel = ncyc - op_base;
        if (prev_ok) begin
            check("debug_en_delay", debug_en, prev_rst ? prev_halt : 1'b0);
            if (prev_rst && prev_valid && !prev_ready) begin
                check("stall_valid", out_valid, 1);
                check("stall_addr", out_addr, prev_oaddr);
                check("stall_data", out_data, prev_odata);
            end
        end
        if (out_valid) begin
            check("send_addr_match", debug_addr, out_addr);
            m_valid_cnt++;
            if (m_first_valid < 0) m_first_valid = rel;
            if (out_ready) begin
                check("word_addr", out_addr, m_exp_addr);
                check("word_data", out_data, data_fn(out_addr, seed));
                m_exp_addr++;
                m_words++;
            end
        end
        if (debug_step) begin
            m_step_cnt++;
            if (!prev_step) begin
                m_step_rises++;
                if (m_step_first < 0) m_step_first = rel;
            end
        end
        if (busy) m_busy_cnt++;
        if (done) begin
            m_done_cnt++;
            m_done_rel = rel;
        end
        prev_ok    = 1'b1;
        prev_rst   = rst;
        prev_halt  = halt_req;
        prev_valid = out_valid;
        prev_ready = out_ready;
        prev_step  = debug_step;
        prev_oaddr = out_addr;
        prev_odata = out_data;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        op_base       = ncyc;
        m_words       = 0;
        m_first_valid = -1;
        m_step_cnt    = 0;
        m_step_rises  = 0;
        m_step_first  = -1;
        m_done_cnt    = 0;
        m_done_rel    = -1;
        m_busy_cnt    = 0;
        m_valid_cnt   = 0;
        m_exp_addr    = 7'd0;
    endtask

    // Reference expectations from the operation rules, for random entries.
    function automatic vec_t ref_expect(input bit md, input bit hl);
        vec_t v;
        bit   stepping;
        stepping    = md && hl;
        v.mode      = md;
        v.halt      = hl;
        v.kind      = 2;
        v.restart   = 1'b0;
        v.halt_drop = 1'b0;
        v.exp_step  = stepping ? STEP_CYC : 0;
        v.exp_lat   = stepping ? 2 * STEP_CYC + SETTLE_CYC + 1 : SETTLE_CYC + 1;
        v.exp_valid = -1;
        v.exp_done  = -1;
        return v;
    endfunction

    task automatic run_op(input int idx, input vec_t v);
        int stall_left;
        int i;
        halt_req  = v.halt;
        out_ready = 1'b1;
        seed      = $urandom;
        repeat (3) tick();
        mode  = v.mode;
        start = 1'b1;
        tick();
        start = 1'b0;
        mode  = 1'(($urandom));
        clear_mon();
        stall_left = 10;
        i = 0;
        while (m_done_cnt == 0 && i < BUDGET) begin
            case (v.kind)
                0: out_ready = 1'b1;
                1: begin
                    if (out_valid && out_addr == 7'd5 && stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else if (debug_addr == 7'd5 && stall_left > 0) begin
                        out_ready = 1'b0;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            start = v.restart && (i == 5 || i == 50);
            if (v.halt_drop && i == 2) halt_req = 1'b0;
            tick();
            i++;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
        check($sformatf("v%0d_done_count", idx), m_done_cnt, 1);
        check($sformatf("v%0d_words", idx), m_words, N_WORDS);
        check($sformatf("v%0d_step_cycles", idx), m_step_cnt, v.exp_step);
        check($sformatf("v%0d_step_pulses", idx), m_step_rises, (v.exp_step > 0) ? 1 : 0);
        if (v.exp_step > 0) check($sformatf("v%0d_step_start", idx), m_step_first, 1);
        check($sformatf("v%0d_first_valid", idx), m_first_valid, v.exp_lat);
        check($sformatf("v%0d_busy_cycles", idx), m_busy_cnt, m_done_rel);
        check($sformatf("v%0d_idle_busy", idx), busy, 0);
        check($sformatf("v%0d_addr_hold", idx), debug_addr, 63);
        if (v.exp_valid >= 0) check($sformatf("v%0d_valid_cycles", idx), m_valid_cnt, v.exp_valid);
        if (v.exp_done >= 0) check($sformatf("v%0d_done_cycle", idx), m_done_rel, v.exp_done);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_debug_en"}, debug_en, 0);
        check({tag, "_debug_step"}, debug_step, 0);
        check({tag, "_debug_addr"}, debug_addr, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_addr"}, out_addr, 0);
        check({tag, "_out_data"}, out_data, 0);
    endtask

    initial begin
        int n1_words, n1_done;
        logic [6:0]  w1_addr;
        logic [31:0] w1_data;

        rst = 1'b0; halt_req = 1'b1; start = 1'b0; mode = 1'b0;
        out_ready = 1'b1; start1 = 1'b0; seed = 32'h0;
        clear_mon();

        // Fixed operations: stepping sweep, no-step paths, stall, restart, halt drop.
        vecs[0] = '{1'b1, 1'b1, 0, 1'b0, 1'b0, 4, 11, 64, 201};
        vecs[1] = '{1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 3, 64, 193};
        vecs[2] = '{1'b0, 1'b1, 0, 1'b0, 1'b0, 0, 3, 64, 193};
        vecs[3] = '{1'b1, 1'b1, 1, 1'b0, 1'b0, 4, 11, 74, 211};
        vecs[4] = '{1'b1, 1'b1, 0, 1'b1, 1'b0, 4, 11, 64, 201};
        vecs[5] = '{1'b1, 1'b1, 0, 1'b0, 1'b1, 4, 11, 64, 201};
        vecs[6] = '{1'b0, 1'b0, 2, 1'b0, 1'b0, 0, 3, -1, -1};
        for (int k = 7; k < N_VEC; k++) begin
            vecs[k] = ref_expect(1'($urandom), 1'($urandom));
        end

        repeat (3) tick();
        check_reset_outputs("por");
        rst = 1'b1;

        for (int k = 0; k < N_VEC; k++) begin
            run_op(k, vecs[k]);
        end

        // Reset while stepping abandons the operation.
        halt_req = 1'b1;
        repeat (3) tick();
        mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("pre_rst_step", debug_step, 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_reset_outputs("rst_step");
        run_op(99, vecs[0]);

        // Reset while a word is waiting drops out_valid, with no done pulse.
        out_ready = 1'b0; mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10 && !out_valid; k++) tick();
        check("pre_rst_valid", out_valid, 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("rst_send_valid", out_valid, 0);
        check("rst_send_busy", busy, 0);
        clear_mon();
        repeat (5) tick();
        check("rst_send_no_done", m_done_cnt, 0);
        out_ready = 1'b1;

        // Single-address sweep at 32.
        n1_words = 0; n1_done = 0; w1_addr = '0; w1_data = '0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (out_valid1) begin
                n1_words++;
                w1_addr = out_addr1;
                w1_data = out_data1;
            end
            if (done1) n1_done++;
            check("one_no_step", debug_step1, 0);
            tick();
        end
        check("one_words", n1_words, 1);
        check("one_addr", w1_addr, 32);
        check("one_data", w1_data, 32'h20);
        check("one_done", n1_done, 1);
        check("one_busy", busy1, 0);
        check("one_addr_hold", debug_addr1, 32);
        check("one_debug_en", debug_en1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debug_dump_ctrl.md
DEBUG_DUMP_CTRL -- requirements
Module: debug_dump_ctrl

Interface
REQ-001 Parameter ADDR_FIRST, 0, first debug address read in a sweep (7-bit value).
REQ-002 Parameter ADDR_LAST, 63, last debug address read in a sweep; ADDR_FIRST <= ADDR_LAST is required, and other values are illegal.
REQ-003 Parameter STEP_CYC, 4, clk cycles debug_step is held high, then held low, per step (>=1).
REQ-004 Parameter SETTLE_CYC, 2, clk cycles between driving debug_addr and sampling debug_data (>=1).
REQ-005 One clock; reset is synchronous and active-low.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst  input  1  synchronous reset, active-low (0 = reset).
REQ-008 halt_req  input  1  level; 1 = hold core under debug clock.
REQ-009 start  input  1  one-cycle request to begin an operation.
REQ-010 mode  input  1  sampled with start: 0 = dump only, 1 = step then dump.
REQ-011 busy  output  1  1 whenever the FSM is not in IDLE.
REQ-012 done  output  1  one-cycle pulse at operation completion.
REQ-013 debug_en  output  1  registered copy of halt_req, to core debug_en.
REQ-014 debug_step  output  1  step clock to core.
REQ-015 debug_addr  output  7  address to core debug port.
REQ-016 debug_data  input  32  data from core debug port.
REQ-017 out_valid  output  1  captured word available.
REQ-018 out_ready  input  1  sink accepts word.
REQ-019 out_addr  output  7  address of captured word.
REQ-020 out_data  output  32  captured debug_data.

Function
REQ-021 The FSM SHALL have states IDLE, STEP_HI, STEP_LO, SETTLE, SEND, DONE.
REQ-022 debug_en SHALL equal halt_req delayed by one clk and SHALL be updated in every state.
REQ-023 In IDLE with start=1, the FSM SHALL go to STEP_HI if mode=1 and debug_en=1; otherwise it SHALL go to SETTLE with debug_addr=ADDR_FIRST.
REQ-024 In STEP_HI, debug_step SHALL be 1 for exactly STEP_CYC cycles; the FSM SHALL then enter STEP_LO.
REQ-025 In STEP_LO, debug_step SHALL be 0 for exactly STEP_CYC cycles; the FSM SHALL then load debug_addr=ADDR_FIRST and enter SETTLE.
REQ-026 debug_step SHALL be 0 in every state except STEP_HI and SHALL be glitch-free (registered).
REQ-027 In SETTLE, the FSM SHALL wait SETTLE_CYC cycles; on the last cycle it SHALL register out_data=debug_data and out_addr=debug_addr, then enter SEND.
REQ-028 In SEND, out_valid SHALL be 1, with out_data and out_addr held stable until out_valid&out_ready.
REQ-029 On a SEND handshake with debug_addr==ADDR_LAST, the FSM SHALL enter DONE; otherwise it SHALL set debug_addr+1 and enter SETTLE.
REQ-030 debug_addr SHALL never wrap; the sweep SHALL end at ADDR_LAST.
REQ-031 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-032 start while busy=1 SHALL be ignored and not queued.
REQ-033 A halt_req change mid-operation SHALL not abort the operation; an in-progress step pulse SHALL complete.
REQ-034 Words per operation SHALL equal ADDR_LAST-ADDR_FIRST+1 and SHALL be emitted in ascending address order.
REQ-035 Dump latency per word with out_ready held at 1 SHALL be SETTLE_CYC+1 cycles.
REQ-036 debug_addr SHALL hold its last value in IDLE.

Reset
REQ-037 With rst=0 at a clk edge, the FSM SHALL go to IDLE and SHALL set busy=0, done=0, debug_en=0, debug_step=0, debug_addr=0, out_valid=0, out_addr=0, out_data=0.
REQ-038 Reset mid-operation, including during STEP_HI or SEND, SHALL take effect on the next edge, abandoning the operation with no done pulse and out_valid dropping to 0.

Verification
REQ-039 Default parameters, halt_req=1, start with mode=1, out_ready=1 -> debug_step high for 4 cycles, then low for 4; 64 words are emitted with out_addr 0..63 in order; done pulses once; busy is low afterwards.
REQ-040 halt_req=0, start with mode=1 -> no debug_step pulse; the dump proceeds directly from address 0.
REQ-041 Sink stalls out_ready=0 for 10 cycles at address 5 -> out_valid stays 1 and out_data/out_addr stay stable; address 6 is not driven until the handshake.
REQ-042 start pulsed again while busy -> ignored; exactly 64 words and one done result.
REQ-043 ADDR_FIRST=ADDR_LAST=32, debug_data model returns {25'h0,debug_addr} -> one word with out_addr=32 and out_data=0x20, then done.
REQ-044 rst=0 asserted during STEP_HI -> next cycle debug_step=0, busy=0, all outputs at reset values; a subsequent start runs normally.
